// File: rtl/prg_saver_if.sv
// Memory read port and outgoing byte-stream port of the PRG saver.
// The saver drives through the master modport; RAM and consumer sit on the slave side.
interface prg_saver_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_dout;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output mem_addr, mem_rd, out_data, out_valid, out_last,
        input  mem_dout, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd, out_data, out_valid, out_last,
        output mem_dout, out_ready
    );
endinterface

// File: rtl/prg_saver.sv
// Snapshots the VIC-20 BASIC program area and streams it as a .PRG byte stream.
// Optional running XOR checksum on csum when PRG_SAVER_CSUM_EN is defined.
module prg_saver #(
    parameter logic [15:0] PTR_START = 16'h002B,
    parameter logic [15:0] PTR_END   = 16'h002D,
    parameter logic [15:0] MAX_ADDR  = 16'hA000,
    parameter int          RAM_LAT   = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    prg_saver_if.master bus,
    output logic [16:0] length,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  csum
);
    typedef enum logic [3:0] {
        IDLE, PTR, CALC, HDR_LO, HDR_HI, FETCH, WAIT, HOLD, FIN
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

    state_t      state_reg;
    logic [15:0] mem_addr_reg;
    logic        mem_rd_reg;
    logic [7:0]  out_data_reg;
    logic        out_valid_reg;
    logic        out_last_reg;
    logic [16:0] length_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic [15:0] start_ptr_reg;
    logic [15:0] end_ptr_reg;
    logic [15:0] end_c_reg;
    logic [15:0] cur_reg;
    logic [1:0]  ptr_idx_reg;
    logic        ptr_wait_reg;
    logic [1:0]  lat_cnt_reg;
    logic [15:0] end_clamped;
    logic        accept;

    assign end_clamped = (end_ptr_reg > MAX_ADDR) ? MAX_ADDR : end_ptr_reg;
    assign accept      = out_valid_reg && bus.out_ready;

    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_rd    = mem_rd_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign length        = length_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            mem_addr_reg  <= 16'h0000;
            mem_rd_reg    <= 1'b0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            length_reg    <= 17'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            start_ptr_reg <= 16'h0000;
            end_ptr_reg   <= 16'h0000;
            end_c_reg     <= 16'h0000;
            cur_reg       <= 16'h0000;
            ptr_idx_reg   <= 2'd0;
            ptr_wait_reg  <= 1'b0;
            lat_cnt_reg   <= 2'd0;
        end else begin
            mem_rd_reg <= 1'b0;
            done_reg   <= 1'b0;
            // Abort beats acceptance; any read still in flight is simply never captured.
            if (abort && state_reg != IDLE) begin
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                busy_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            state_reg    <= PTR;
                            busy_reg     <= 1'b1;
                            err_reg      <= 1'b0;
                            mem_addr_reg <= PTR_START;
                            mem_rd_reg   <= 1'b1;
                            ptr_idx_reg  <= 2'd0;
                            ptr_wait_reg <= 1'b0;
                        end
                    end
                    PTR: begin
                        if (!ptr_wait_reg) begin
                            ptr_wait_reg <= 1'b1;
                            lat_cnt_reg  <= LAT_LOAD;
                        end else if (lat_cnt_reg != 2'd0) begin
                            lat_cnt_reg <= lat_cnt_reg - 2'd1;
                        end else begin
                            case (ptr_idx_reg)
                                2'd0:    start_ptr_reg[7:0]  <= bus.mem_dout;
                                2'd1:    start_ptr_reg[15:8] <= bus.mem_dout;
                                2'd2:    end_ptr_reg[7:0]    <= bus.mem_dout;
                                default: end_ptr_reg[15:8]   <= bus.mem_dout;
                            endcase
                            if (ptr_idx_reg == 2'd3) begin
                                state_reg <= CALC;
                            end else begin
                                ptr_idx_reg  <= ptr_idx_reg + 2'd1;
                                ptr_wait_reg <= 1'b0;
                                mem_rd_reg   <= 1'b1;
                                mem_addr_reg <= (ptr_idx_reg == 2'd1) ? PTR_END : mem_addr_reg + 16'd1;
                            end
                        end
                    end
                    CALC: begin
                        end_c_reg <= end_clamped;
                        cur_reg   <= start_ptr_reg;
                        if (end_clamped <= start_ptr_reg) begin
                            err_reg    <= 1'b1;
                            length_reg <= 17'd2;
                        end else begin
                            length_reg <= {1'b0, end_clamped} - {1'b0, start_ptr_reg} + 17'd2;
                        end
                        state_reg     <= HDR_LO;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= start_ptr_reg[7:0];
                        out_last_reg  <= 1'b0;
                    end
                    HDR_LO: begin
                        if (accept) begin
                            state_reg    <= HDR_HI;
                            out_data_reg <= start_ptr_reg[15:8];
                            out_last_reg <= err_reg;
                        end
                    end
                    HDR_HI: begin
                        if (accept) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            if (err_reg) begin
                                state_reg <= FIN;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg    <= FETCH;
                                mem_addr_reg <= cur_reg;
                                mem_rd_reg   <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        state_reg   <= WAIT;
                        lat_cnt_reg <= LAT_LOAD;
                    end
                    WAIT: begin
                        if (lat_cnt_reg != 2'd0) begin
                            lat_cnt_reg <= lat_cnt_reg - 2'd1;
                        end else begin
                            state_reg     <= HOLD;
                            out_data_reg  <= bus.mem_dout;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (cur_reg == end_c_reg - 16'd1);
                        end
                    end
                    HOLD: begin
                        if (accept) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            if (out_last_reg) begin
                                state_reg <= FIN;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg    <= FETCH;
                                cur_reg      <= cur_reg + 16'd1;
                                mem_addr_reg <= cur_reg + 16'd1;
                                mem_rd_reg   <= 1'b1;
                            end
                        end
                    end
                    FIN: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PRG_SAVER_CSUM_EN
    logic [7:0] csum_reg;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            csum_reg <= 8'h00;
        end else if (state_reg == IDLE && start && !abort) begin
            csum_reg <= 8'h00;
        end else if (accept && !abort) begin
            csum_reg <= csum_reg ^ out_data_reg;
        end
    end

    assign csum = csum_reg;
`else
    assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_prg_saver.sv
// Scoreboard bench for prg_saver: three instances with RAM_LAT 1..3 share one RAM image;
// the main process queues expected stream bytes, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_prg_saver;
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] abort = 3'b000;
    logic [2:0] out_ready = 3'b000;

    always #5 clk_sys = ~clk_sys;

    logic [7:0]  mem [0:65535];

    logic [15:0] mem_addr_a [3];
    logic [2:0]  mem_rd_a;
    logic [7:0]  out_data_a [3];
    logic [2:0]  out_valid_a;
    logic [2:0]  out_last_a;
    logic [16:0] length_a [3];
    logic [2:0]  busy_a;
    logic [2:0]  done_a;
    logic [2:0]  err_a;
    logic [7:0]  csum_a [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g
        prg_saver_if bus ();
        logic [2:0]  rd_pipe = 3'b000;
        logic [15:0] addr_pipe [3];

        prg_saver #(.RAM_LAT(gi + 1)) dut (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .start   (start[gi]),
            .abort   (abort[gi]),
            .bus     (bus),
            .length  (length_a[gi]),
            .busy    (busy_a[gi]),
            .done    (done_a[gi]),
            .err     (err_a[gi]),
            .csum    (csum_a[gi])
        );

        // RAM model: data only on the cycle exactly RAM_LAT after mem_rd, X otherwise.
        always @(posedge clk_sys) begin
            rd_pipe      <= {rd_pipe[1:0], bus.mem_rd};
            addr_pipe[0] <= bus.mem_addr;
            addr_pipe[1] <= addr_pipe[0];
            addr_pipe[2] <= addr_pipe[1];
        end

        assign bus.mem_dout     = rd_pipe[gi] ? mem[addr_pipe[gi]] : 8'hxx;
        assign bus.out_ready    = out_ready[gi];
        assign mem_addr_a[gi]   = bus.mem_addr;
        assign mem_rd_a[gi]     = bus.mem_rd;
        assign out_data_a[gi]   = bus.out_data;
        assign out_valid_a[gi]  = bus.out_valid;
        assign out_last_a[gi]   = bus.out_last;
    end

    exp_t       exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         rd_cnt = 0;
    int         drd_cnt = 0;
    logic [1:0] act = 2'd0;
    logic       clr_req = 1'b0;
    logic       rst_req = 1'b0;
    logic       stat_req = 1'b0;
    logic       abt_req = 1'b0;
    logic       tmo_req = 1'b0;
    logic [16:0] exp_len = '0;
    logic        exp_err = 1'b0;
    logic [7:0]  exp_csum = 8'h00;
    int          exp_rd = 0;
    int          exp_drd = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endfunction

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       acc_last;
        exp_t       e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        acc_last   = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (clr_req) begin
                rd_cnt  = 0;
                drd_cnt = 0;
            end else if (mem_rd_a[act]) begin
                rd_cnt++;
                if (mem_addr_a[act] >= 16'h0100) drd_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid_a[act]), 32'd1);
                chk("hold_data", 32'(out_data_a[act]), 32'(prev_data));
                chk("hold_last", 32'(out_last_a[act]), 32'(prev_last));
            end
            if (done_a[act] || acc_last) chk("done_pulse", 32'(done_a[act]), 32'(acc_last));
            acc_last = 1'b0;
            if (out_valid_a[act] && out_ready[act] && !abort[act]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte got=%02h expected=none", out_data_a[act]);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'(out_data_a[act]), 32'(e.d));
                    chk("last", 32'(out_last_a[act]), 32'(e.l));
                    acc_last = e.l;
                    $display("inst%0d byte=%02h last=%0b", act, out_data_a[act], out_last_a[act]);
                end
            end
            prev_stall = reset_n && out_valid_a[act] && !out_ready[act] && !abort[act];
            prev_data  = out_data_a[act];
            prev_last  = out_last_a[act];
            if (rst_req) begin
                chk("rst_mem_addr", 32'(mem_addr_a[act]), 32'd0);
                chk("rst_mem_rd", 32'(mem_rd_a[act]), 32'd0);
                chk("rst_out_data", 32'(out_data_a[act]), 32'd0);
                chk("rst_out_valid", 32'(out_valid_a[act]), 32'd0);
                chk("rst_out_last", 32'(out_last_a[act]), 32'd0);
                chk("rst_length", 32'(length_a[act]), 32'd0);
                chk("rst_busy", 32'(busy_a[act]), 32'd0);
                chk("rst_done", 32'(done_a[act]), 32'd0);
                chk("rst_err", 32'(err_a[act]), 32'd0);
                chk("rst_csum", 32'(csum_a[act]), 32'd0);
                chk("rst_queue", 32'(exp_q.size()), 32'd0);
                $display("inst%0d reset state checked", act);
            end
            if (stat_req) begin
                chk("length", 32'(length_a[act]), 32'(exp_len));
                chk("err", 32'(err_a[act]), 32'(exp_err));
                chk("csum", 32'(csum_a[act]), 32'(exp_csum));
                chk("mem_rd_total", 32'(rd_cnt), 32'(exp_rd));
                chk("mem_rd_data", 32'(drd_cnt), 32'(exp_drd));
                chk("busy_after", 32'(busy_a[act]), 32'd0);
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                $display("inst%0d save done length=%0d err=%0b csum=%02h reads=%0d", act,
                         length_a[act], err_a[act], csum_a[act], rd_cnt);
            end
            if (abt_req) begin
                chk("abort_valid", 32'(out_valid_a[act]), 32'd0);
                chk("abort_busy", 32'(busy_a[act]), 32'd0);
                chk("abort_queue", 32'(exp_q.size()), 32'd0);
                $display("inst%0d abort checked", act);
            end
            if (tmo_req) begin
                checks++;
                failures++;
                $display("FAIL timeout inst=%0d got=no_event expected=event", act);
            end
        end
    end

    function automatic logic [7:0] cs(input logic [7:0] x);
`ifdef PRG_SAVER_CSUM_EN
        return x;
`else
        return x & 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic req_pulse(input int which);
        case (which)
            0: clr_req = 1'b1;
            1: rst_req = 1'b1;
            2: stat_req = 1'b1;
            3: abt_req = 1'b1;
            default: tmo_req = 1'b1;
        endcase
        @(negedge clk_sys);
        #1;
        clr_req  = 1'b0;
        rst_req  = 1'b0;
        stat_req = 1'b0;
        abt_req  = 1'b0;
        tmo_req  = 1'b0;
    endtask

    task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
        mem[16'h002B] = s[7:0];
        mem[16'h002C] = s[15:8];
        mem[16'h002D] = e[7:0];
        mem[16'h002E] = e[15:8];
    endtask

    task automatic push_basic();
        push(8'h01, 1'b0);
        push(8'h10, 1'b0);
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b0);
        push(8'hDD, 1'b1);
    endtask

    task automatic kick(input logic [1:0] inst);
        act = inst;
        req_pulse(0);
        tick();
        start[inst]     = 1'b1;
        out_ready[inst] = 1'b1;
        tick();
        start[inst] = 1'b0;
    endtask

    task automatic run_save(input logic [1:0] inst, input logic bp, input logic [16:0] len,
                            input logic er, input logic [7:0] c, input int rd, input int drd);
        logic [3:0] pat;
        int         cyc;
        logic       got;
        pat = 4'b1001;
        cyc = 0;
        got = 1'b0;
        kick(inst);
        while (cyc < 300 && !got) begin
            out_ready[inst] = bp ? pat[cyc[1:0]] : 1'b1;
            tick();
            cyc++;
            if (done_a[inst]) got = 1'b1;
        end
        out_ready[inst] = 1'b1;
        if (!got) begin
            req_pulse(4);
        end else begin
            tick();
            exp_len  = len;
            exp_err  = er;
            exp_csum = c;
            exp_rd   = rd;
            exp_drd  = drd;
            req_pulse(2);
        end
        out_ready[inst] = 1'b0;
        tick();
    endtask

    // Run until the given byte sits valid on the stream, then return (found=0 on timeout).
    task automatic run_until(input logic [1:0] inst, input logic [7:0] b, output logic found);
        int cyc;
        cyc   = 0;
        found = 1'b0;
        kick(inst);
        while (cyc < 300 && !found) begin
            out_ready[inst] = 1'b1;
            tick();
            cyc++;
            if (out_valid_a[inst] && out_data_a[inst] == b) found = 1'b1;
        end
    endtask

    initial begin
        logic found;
        mem[16'h1001] = 8'hAA;
        mem[16'h1002] = 8'hBB;
        mem[16'h1003] = 8'hCC;
        mem[16'h1004] = 8'hDD;
        mem[16'h9FFE] = 8'h5A;
        mem[16'h9FFF] = 8'hA5;

        reset_n = 1'b0;
        repeat (3) tick();
        req_pulse(1);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic save
        set_ptrs(16'h1001, 16'h1005);
        push_basic();
        run_save(2'd0, 1'b0, 17'd6, 1'b0, cs(8'h11), 8, 4);

        // Backpressure 1,0,0,1
        push_basic();
        run_save(2'd0, 1'b1, 17'd6, 1'b0, cs(8'h11), 8, 4);

        // Empty program: header only
        set_ptrs(16'h1201, 16'h1201);
        push(8'h01, 1'b0);
        push(8'h12, 1'b1);
        run_save(2'd0, 1'b0, 17'd2, 1'b1, cs(8'h13), 4, 0);

        // Clamp end to MAX_ADDR
        set_ptrs(16'h9FFE, 16'hB000);
        push(8'hFE, 1'b0);
        push(8'h9F, 1'b0);
        push(8'h5A, 1'b0);
        push(8'hA5, 1'b1);
        run_save(2'd0, 1'b0, 17'd4, 1'b0, cs(8'h9E), 6, 2);

        // Abort while the second data byte is held
        set_ptrs(16'h1001, 16'h1005);
        push(8'h01, 1'b0);
        push(8'h10, 1'b0);
        push(8'hAA, 1'b0);
        run_until(2'd0, 8'hBB, found);
        if (!found) begin
            req_pulse(4);
        end else begin
            abort[0] = 1'b1;
            tick();
            abort[0] = 1'b0;
            req_pulse(3);
        end
        out_ready[0] = 1'b0;
        repeat (5) tick();
        exp_q.delete();

        // Full save after abort
        push_basic();
        run_save(2'd0, 1'b0, 17'd6, 1'b0, cs(8'h11), 8, 4);

        // Reset mid-stream
        push(8'h01, 1'b0);
        push(8'h10, 1'b0);
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        run_until(2'd0, 8'hCC, found);
        if (!found) begin
            req_pulse(4);
            exp_q.delete();
        end
        reset_n      = 1'b0;
        out_ready[0] = 1'b0;
        tick();
        req_pulse(1);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // Latency sweep on the other instances
        push_basic();
        run_save(2'd1, 1'b0, 17'd6, 1'b0, cs(8'h11), 8, 4);
        push_basic();
        run_save(2'd2, 1'b1, 17'd6, 1'b0, cs(8'h11), 8, 4);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1);
    end
endmodule
